priority_encoder: RTL and testbench
===================================

// Module: priority_encoder
// PURPOSE
//   Registered MSB-first priority encoder. Reports the index of the highest set
//   request bit, a one-hot mask of that bit, and a valid flag.
//   Used wherever a single winner must be picked from a request vector
//   (interrupt/request selection). Outputs are registered on clk.
// PARAMETERS
//   WIDTH   4                   request vector width, >= 2
//   IDX_W   $clog2(WIDTH)       index width, derived, not overridden
// PORTS
//   clk     in   1      single clock, rising edge
//   rst     in   1      asynchronous, active-high reset
//   en      in   1      capture enable; low = hold all outputs
//   in      in   WIDTH  request vector, bit WIDTH-1 is highest priority
//   out     out  IDX_W  index of highest set bit of in
//   onehot  out  WIDTH  one-hot mask of the winning bit; all-zero if none
//   valid   out  1      1 when at least one bit of in was set
// BEHAVIOUR
//   - Reset: asynchronous, active-high. While rst=1: out=0, onehot=0, valid=0,
//     immediately, without waiting for a clk edge. Release takes effect at the
//     next rising clk edge.
//   - Priority: out = largest i such that in[i]=1. Lower bits are don't-care
//     once a higher bit is set.
//   - Latency: 1 cycle. At a rising edge with en=1, in is sampled. out, onehot
//     and valid update together from that sample. All three stay stable until
//     the next enabled edge.
//   - en=0: all outputs hold their previous values; in is ignored.
//   - Zero input (in=0): out=0, onehot=0, valid=0. out=0 alone is ambiguous;
//     consumers must qualify it with valid.
//   - onehot = 1 << out when valid=1; onehot is never multi-hot.
//   - Encode logic is purely combinational, with no state beyond the output
//     registers. It is built generically over WIDTH by a loop or for-generate,
//     not a hard-coded case.
//   - X/Z on in is not handled.
// TESTING
//   - Reset: assert rst mid-cycle with valid=1 -> outputs go to 0 at once,
//     without a clk edge; deassert -> first enabled edge loads normally.
//   - Priority vectors (WIDTH=4, en=1), one cycle after each:
//       0101->out=10 onehot=0100 valid=1
//       1011->11/1000/1
//       0110->10/0100/1
//       0010->01/0010/1
//       0001->00/0001/1
//       1010->11/1000/1
//   - Zero: in=0000 -> out=00, onehot=0000, valid=0.
//   - Hold: load 1011 (out=11), drop en, apply 0001 for 3 cycles -> out=11 and
//     valid=1 unchanged; raise en -> out=00 next cycle.
//   - Exhaustive: all 16 inputs vs reference model; then WIDTH=8:
//     in=8'h21 -> out=101, onehot=8'h20.
//   - Latency: change in every cycle -> each output reflects the input sampled
//     exactly one edge earlier.

Source files
------------

// File: rtl/priority_encoder.sv
// -----------------------------------------------------------------------------
// priority_encoder
//   Registered MSB-first priority encoder. Picks the highest set bit of the
//   request vector and reports its index, a one-hot mask of it, and a valid
//   flag. All three outputs are registered and update together on an enabled
//   rising clock edge, one cycle after the request vector is sampled.
//
// Parameters
//   WIDTH   request vector width (>= 2)
//   IDX_W   index width, derived as $clog2(WIDTH)
//
// Ports
//   clk     in   1      rising-edge clock
//   rst     in   1      asynchronous, active-high reset (clears all outputs)
//   en      in   1      capture enable; low holds all outputs
//   in      in   WIDTH  request vector, bit WIDTH-1 has highest priority
//   out     out  IDX_W  index of the highest set bit of the sampled vector
//   onehot  out  WIDTH  one-hot mask of the winning bit, all-zero if none
//   valid   out  1      high when the sampled vector had any bit set
// -----------------------------------------------------------------------------
module priority_encoder #(
    parameter  int WIDTH = 4,
    localparam int IDX_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] in,
    output logic [IDX_W-1:0] out,
    output logic [WIDTH-1:0] onehot,
    output logic             valid
);

    // Combinational encode results
    logic [IDX_W-1:0] enc_idx_s;
    logic [WIDTH-1:0] enc_onehot_s;
    logic             enc_hit_s;

    // Next-state values for the output registers
    logic [IDX_W-1:0] out_d;
    logic [WIDTH-1:0] onehot_d;
    logic             valid_d;

    // Output registers
    logic [IDX_W-1:0] out_q;
    logic [WIDTH-1:0] onehot_q;
    logic             valid_q;

    // Generic MSB-first encode: scanning upward, a later (higher) set bit
    // overwrites any earlier one, so the highest set bit wins.
    always_comb begin
        enc_idx_s = {IDX_W{1'b0}};
        enc_hit_s = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (in[i]) begin
                enc_idx_s = IDX_W'(i);
                enc_hit_s = 1'b1;
            end else begin
                enc_idx_s = enc_idx_s;
                enc_hit_s = enc_hit_s;
            end
        end
    end

    // One-hot mask derived from the winning index; forced to zero when no bit
    // is set so it can never disagree with valid.
    always_comb begin
        enc_onehot_s = {WIDTH{1'b0}};
        if (enc_hit_s) begin
            enc_onehot_s = {{(WIDTH-1){1'b0}}, 1'b1} << enc_idx_s;
        end else begin
            enc_onehot_s = {WIDTH{1'b0}};
        end
    end

    // Capture a new encode result only when enabled, otherwise hold.
    always_comb begin
        out_d    = out_q;
        onehot_d = onehot_q;
        valid_d  = valid_q;
        if (en) begin
            out_d    = enc_idx_s;
            onehot_d = enc_onehot_s;
            valid_d  = enc_hit_s;
        end else begin
            out_d    = out_q;
            onehot_d = onehot_q;
            valid_d  = valid_q;
        end
    end

    // Output registers with asynchronous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q    <= {IDX_W{1'b0}};
            onehot_q <= {WIDTH{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            out_q    <= out_d;
            onehot_q <= onehot_d;
            valid_q  <= valid_d;
        end
    end

    assign out    = out_q;
    assign onehot = onehot_q;
    assign valid  = valid_q;

endmodule

// File: tb/tb_priority_encoder.sv
module tb_priority_encoder;

    typedef struct {
        logic [1:0] out;
        logic [3:0] oh;
        logic       v;
        string      tag;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       en_s;
    logic [3:0] in_s;
    logic [1:0] out_s;
    logic [3:0] onehot_s;
    logic       valid_s;

    logic       en8_s;
    logic [7:0] in8_s;
    logic [2:0] out8_s;
    logic [7:0] onehot8_s;
    logic       valid8_s;

    int checks;
    int errors;

    exp_t sb_q[$];

    // reference state for the 4-bit DUT
    logic [1:0] m_out;
    logic [3:0] m_oh;
    logic       m_v;

    priority_encoder #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .rst    (rst),
        .en     (en_s),
        .in     (in_s),
        .out    (out_s),
        .onehot (onehot_s),
        .valid  (valid_s)
    );

    priority_encoder #(.WIDTH(8)) dut8 (
        .clk    (clk),
        .rst    (rst),
        .en     (en8_s),
        .in     (in8_s),
        .out    (out8_s),
        .onehot (onehot8_s),
        .valid  (valid8_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: search downward from the MSB, first hit wins.
    function automatic exp_t model4(input logic [3:0] v, input string tag);
        exp_t e;
        e.out = 2'd0;
        e.oh  = 4'b0000;
        e.v   = 1'b0;
        e.tag = tag;
        for (int i = 3; i >= 0; i--) begin
            if (v[i] && !e.v) begin
                e.out = 2'(i);
                e.v   = 1'b1;
            end
        end
        if (e.v) e.oh[e.out] = 1'b1;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, push expectation at the edge, pop and
    // compare just after it.
    task automatic step(input logic [3:0] v, input logic e, input string tag);
        exp_t ex;
        exp_t got;
        @(negedge clk);
        in_s = v;
        en_s = e;
        @(posedge clk);
        if (e) begin
            ex    = model4(v, tag);
            m_out = ex.out;
            m_oh  = ex.oh;
            m_v   = ex.v;
        end
        ex.out = m_out;
        ex.oh  = m_oh;
        ex.v   = m_v;
        ex.tag = tag;
        sb_q.push_back(ex);
        #1;
        got = sb_q.pop_front();
        chk(got.tag, {9'd0, out_s, onehot_s, valid_s}, {9'd0, got.out, got.oh, got.v});
    endtask

    initial begin
        checks = 0;
        errors = 0;
        m_out  = 2'd0;
        m_oh   = 4'd0;
        m_v    = 1'b0;
        rst    = 1'b1;
        en_s   = 1'b0;
        in_s   = 4'd0;
        en8_s  = 1'b0;
        in8_s  = 8'd0;

        #1;
        chk("reset_initial", {9'd0, out_s, onehot_s, valid_s}, 16'd0);
        chk("reset_initial8", {4'd0, out8_s, onehot8_s, valid8_s}, 16'd0);

        @(negedge clk);
        rst = 1'b0;

        // priority vectors
        step(4'b0101, 1'b1, "pri_0101");
        step(4'b1011, 1'b1, "pri_1011");
        step(4'b0110, 1'b1, "pri_0110");
        step(4'b0010, 1'b1, "pri_0010");
        step(4'b0001, 1'b1, "pri_0001");
        step(4'b1010, 1'b1, "pri_1010");
        step(4'b0000, 1'b1, "zero");
        chk("zero_direct", {9'd0, out_s, onehot_s, valid_s}, {9'd0, 2'b00, 4'b0000, 1'b0});

        // hold
        step(4'b1011, 1'b1, "hold_load");
        step(4'b0001, 1'b0, "hold_1");
        step(4'b0001, 1'b0, "hold_2");
        step(4'b0001, 1'b0, "hold_3");
        chk("hold_direct", {9'd0, out_s, onehot_s, valid_s}, {9'd0, 2'b11, 4'b1000, 1'b1});
        step(4'b0001, 1'b1, "hold_release");
        chk("hold_release_direct", {9'd0, out_s, onehot_s, valid_s}, {9'd0, 2'b00, 4'b0001, 1'b1});

        // asynchronous reset mid-cycle with valid=1
        step(4'b1100, 1'b1, "pre_reset");
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset", {9'd0, out_s, onehot_s, valid_s}, 16'd0);
        m_out = 2'd0;
        m_oh  = 4'd0;
        m_v   = 1'b0;
        #1;
        rst = 1'b0;
        step(4'b0100, 1'b1, "post_reset");

        // exhaustive
        for (int k = 0; k < 16; k++) begin
            step(4'(k), 1'b1, $sformatf("exh_%0d", k));
        end

        // latency: new random input every cycle, occasional en drops
        for (int k = 0; k < 24; k++) begin
            step(4'($urandom_range(0, 15)), (k % 5 != 3) ? 1'b1 : 1'b0,
                 $sformatf("lat_%0d", k));
        end

        // WIDTH=8 instance
        @(negedge clk);
        in8_s = 8'h21;
        en8_s = 1'b1;
        @(posedge clk);
        #1;
        chk("w8_21", {4'd0, out8_s, onehot8_s, valid8_s}, {4'd0, 3'd5, 8'h20, 1'b1});
        @(negedge clk);
        in8_s = 8'h81;
        @(posedge clk);
        #1;
        chk("w8_81", {4'd0, out8_s, onehot8_s, valid8_s}, {4'd0, 3'd7, 8'h80, 1'b1});
        @(negedge clk);
        in8_s = 8'h00;
        @(posedge clk);
        #1;
        chk("w8_00", {4'd0, out8_s, onehot8_s, valid8_s}, 16'd0);
        @(negedge clk);
        in8_s = 8'h03;
        @(posedge clk);
        #1;
        chk("w8_03", {4'd0, out8_s, onehot8_s, valid8_s}, {4'd0, 3'd1, 8'h02, 1'b1});

        chk("sb_empty", 16'(sb_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
